prbs_gen_chk: RTL and testbench

Parametrised PRBS source and self-synchronising checker for the QPSK link. The generator emits N_CH bits per enable strobe from a Fibonacci LFSR of selectable order, replacing the fixed 9-bit, 1-bit-per-step PRBS. N_CH=2 feeds the I and Q branches directly. The checker locks onto a received stream, counts bit errors and reports lock state, so the FPGA can measure BER on the loopback path.

---
 rtl/prbs_gen_chk.sv | 160 ++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: N_CH-bit-per-strobe Fibonacci PRBS generator plus self-synchronising BER checker.
// Define PRBS_ERR_INJ_EN to let i_inject invert bit 0 of the generated word.
module prbs_gen_chk #(
  parameter int              ORDER     = 9,
  parameter logic [ORDER-1:0] SEED     = 9'b110101010,
  parameter int              N_CH      = 2,
  parameter int              LOCK_BITS = 64,
  parameter int              WIN_WORDS = 32,
  parameter int              LOSS_THR  = 8,
  parameter int              ERR_W     = 32
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_inject,
  input  logic [N_CH-1:0]  i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_clr_cnt,
  output logic [N_CH-1:0]  o_data,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt
);
  localparam int TAP = ORDER == 7 ? 6 : ORDER == 9 ? 5 : ORDER == 15 ? 14 :
                       ORDER == 23 ? 18 : ORDER == 31 ? 28 : 0;
  localparam int FW  = $clog2(ORDER + N_CH + 1);
  localparam int GW  = $clog2(LOCK_BITS + 1);
  localparam int WW  = $clog2(WIN_WORDS + 1);
  localparam int TW  = $clog2(LOSS_THR + N_CH + 1);
  localparam int PW  = $clog2(N_CH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(ORDER);
  localparam logic [FW-1:0] N_CH_V    = FW'(N_CH);
  localparam logic [GW-1:0] LOCK_V    = GW'(LOCK_BITS);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_WORDS - 1);
  localparam logic [TW-1:0] THR_V     = TW'(LOSS_THR);

  generate
    if (TAP == 0) begin : g_bad_order
      $error("prbs_gen_chk: unsupported ORDER %0d", ORDER);
    end
    if (SEED == '0) begin : g_bad_seed
      $error("prbs_gen_chk: SEED must be non-zero");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
      $error("prbs_gen_chk: N_CH must be 1..8");
    end
  endgenerate

  typedef enum logic {HUNT, LOCKED} state_t;

  logic [ORDER-1:0] r_s, w_s_nxt;
  logic [N_CH-1:0]  w_word, w_inj;
  logic [ORDER-1:0] r_c, w_c;
  logic [FW-1:0]    r_fill, w_fill_sum, w_fill_nxt;
  logic [GW-1:0]    r_good, w_good;
  logic [WW-1:0]    r_win_words;
  logic [TW-1:0]    r_win_err, w_win_sum;
  logic [N_CH-1:0]  w_e;
  logic [PW-1:0]    w_pop;
  logic [ERR_W:0]   w_sum;
  logic [ERR_W-1:0] w_cnt_sat;
  logic             w_hit, w_chk;
  state_t           r_state;

`ifdef PRBS_ERR_INJ_EN
  assign w_inj = N_CH'(i_inject);
`else
  logic w_unused_inject;
  assign w_unused_inject = i_inject;
  assign w_inj = '0;
`endif

  // N_CH unrolled LFSR steps; bit k of the word is the output of step k
  always_comb begin
    w_s_nxt = r_s;
    w_word  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_word[k] = w_s_nxt[ORDER-1];
      w_s_nxt   = {w_s_nxt[ORDER-2:0], w_s_nxt[ORDER-1] ^ w_s_nxt[TAP-1]};
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst)
    if (!rst) begin
      r_s     <= SEED;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        r_s    <= w_s_nxt;
        o_data <= w_word ^ w_inj;
      end
    end

  // Received bits feed the checker register exactly as the feedback bit would
  always_comb begin
    w_c    = r_c;
    w_e    = '0;
    w_good = r_good;
    w_hit  = 1'b0;
    w_pop  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_e[k] = i_rx_data[k] ^ w_c[ORDER-1] ^ w_c[TAP-1];
      w_c    = {w_c[ORDER-2:0], i_rx_data[k]};
      w_good = w_e[k] ? '0 : (w_good < LOCK_V ? w_good + 1'b1 : w_good);
      w_hit  = w_hit | (w_good == LOCK_V);
      w_pop  = w_pop + PW'(w_e[k]);
    end
  end

  assign w_chk      = i_rx_valid && (r_fill == FILL_FULL);
  assign w_fill_sum = r_fill + N_CH_V;
  assign w_fill_nxt = w_fill_sum >= FILL_FULL ? FILL_FULL : w_fill_sum;
  assign w_sum      = {1'b0, o_err_cnt} + (ERR_W + 1)'(w_pop);
  assign w_cnt_sat  = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
  assign w_win_sum  = r_win_err + TW'(w_pop);
  assign o_lock     = (r_state == LOCKED);

  always_ff @(posedge CLK100MHZ or negedge rst)
    if (!rst) begin
      r_c         <= '0;
      r_fill      <= '0;
      r_good      <= '0;
      r_win_words <= '0;
      r_win_err   <= '0;
      r_state     <= HUNT;
      o_err       <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      o_err <= w_chk && (|w_e);
      if (i_rx_valid) begin
        r_c    <= w_c;
        r_fill <= w_fill_nxt;
      end
      if (i_clr_cnt)
        o_err_cnt <= '0;
      else if (w_chk && r_state == LOCKED)
        o_err_cnt <= w_cnt_sat;
      if (w_chk) begin
        if (r_state == HUNT) begin
          r_good <= w_good;
          if (w_hit)
            r_state <= LOCKED;
        end else if (w_win_sum >= THR_V) begin
          r_state     <= HUNT;
          r_good      <= '0;
          r_win_words <= '0;
          r_win_err   <= '0;
        end else if (r_win_words == WIN_LAST) begin
          r_win_words <= '0;
          r_win_err   <= '0;
        end else begin
          r_win_words <= r_win_words + 1'b1;
          r_win_err   <= w_win_sum;
        end
      end
    end
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk, one N_CH=1 and one N_CH=2 instance.
module tb_prbs_gen_chk;
  localparam logic [8:0] SEED_T = 9'b110101010;
`ifdef PRBS_ERR_INJ_EN
  localparam logic INJ = 1'b1;
  localparam int   INJ_ERRS = 3;
`else
  localparam logic INJ = 1'b0;
  localparam int   INJ_ERRS = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic en1 = 0, inj1 = 0, clr1 = 0, flip1 = 0;
  logic d1, v1, l1, e1, rx1;
  logic [31:0] c1;
  logic en2 = 0, inj2 = 0, clr2 = 0, ovr2 = 0;
  logic v2, l2, e2;
  logic [1:0] d2, rx2;
  logic [31:0] c2;
  logic seq [0:1023];
  int p1 = 0, p2 = 0;
  logic q1 [$];
  logic [1:0] q2 [$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign rx1 = d1 ^ flip1;
  assign rx2 = ovr2 ? 2'b11 : d2;

  prbs_gen_chk #(.ORDER(9), .SEED(9'b110101010), .N_CH(1)) u1 (
    .CLK100MHZ(clk), .rst(rst_n), .i_en(en1), .i_inject(inj1), .i_rx_data(rx1),
    .i_rx_valid(v1), .i_clr_cnt(clr1), .o_data(d1), .o_valid(v1), .o_lock(l1),
    .o_err(e1), .o_err_cnt(c1));

  prbs_gen_chk #(.ORDER(9), .SEED(9'b110101010), .N_CH(2)) u2 (
    .CLK100MHZ(clk), .rst(rst_n), .i_en(en2), .i_inject(inj2), .i_rx_data(rx2),
    .i_rx_valid(v2), .i_clr_cnt(clr2), .o_data(d2), .o_valid(v2), .o_lock(l2),
    .o_err(e2), .o_err_cnt(c2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1;
    q1.push_back(seq[p1]);
    p1++;
  endtask

  task automatic push2;
    q2.push_back({seq[p2+1], seq[p2] ^ (inj2 & INJ)});
    p2 += 2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    n_cmp++;
    if ({d1, v1, l1, e1, c1} !== '0) begin
      n_bad++;
      $display("FAIL reset_u1: got data=%0b valid=%0b lock=%0b err=%0b cnt=%0d want all 0", d1, v1, l1, e1, c1);
    end
    n_cmp++;
    if ({d2, v2, l2, e2, c2} !== '0) begin
      n_bad++;
      $display("FAIL reset_u2: got data=%0b valid=%0b lock=%0b err=%0b cnt=%0d want all 0", d2, v2, l2, e2, c2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_gen_seq;
    logic x;
    for (int i = 0; i < 9; i++) begin
      en1 = 1'b1;
      push1();
      tick;
      en1 = 1'b0;
      x = q1.pop_front();
      n_cmp++;
      if (v1 !== 1'b1 || d1 !== x) begin
        n_bad++;
        $display("FAIL gen_sb word %0d: got valid=%0b data=%0b want valid=1 data=%0b", i, v1, d1, x);
      end
      n_cmp++;
      if (d1 !== SEED_T[8-i]) begin
        n_bad++;
        $display("FAIL gen_seed word %0d: got %0b want %0b", i, d1, SEED_T[8-i]);
      end
      tick;
      n_cmp++;
      if (v1 !== 1'b0 || d1 !== SEED_T[8-i]) begin
        n_bad++;
        $display("FAIL gen_hold word %0d: got valid=%0b data=%0b want valid=0 data=%0b", i, v1, d1, SEED_T[8-i]);
      end
    end
  endtask

  task automatic test_lock_u1;
    logic x, err_seen;
    err_seen = 1'b0;
    for (int j = 10; j <= 80; j++) begin
      en1 = 1'b1;
      push1();
      tick;
      x = q1.pop_front();
      err_seen = err_seen | e1;
      n_cmp++;
      if (v1 !== 1'b1 || d1 !== x) begin
        n_bad++;
        $display("FAIL lock_u1_sb word %0d: got valid=%0b data=%0b want valid=1 data=%0b", j, v1, d1, x);
      end
      if (j == 73 || j == 74) begin
        n_cmp++;
        if (l1 !== (j == 74)) begin
          n_bad++;
          $display("FAIL lock_u1 after word %0d: got lock=%0b want %0b", j - 1, l1, j == 74);
        end
      end
    end
    en1 = 1'b0;
    tick;
    n_cmp++;
    if (c1 !== 32'd0 || err_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_u1_clean: got cnt=%0d err_seen=%0b want cnt=0 err_seen=0", c1, err_seen);
    end
  endtask

  task automatic test_clr_cnt;
    logic x;
    en1 = 1'b1;
    push1();
    tick;
    x = q1.pop_front();
    for (int i = 0; i < 14; i++) begin
      en1 = 1'b1;
      push1();
      flip1 = (i == 2);
      clr1 = (i == 7);
      tick;
      x = q1.pop_front();
      n_cmp++;
      if (d1 !== x) begin
        n_bad++;
        $display("FAIL clr_sb step %0d: got %0b want %0b", i, d1, x);
      end
      if (i == 2) begin
        n_cmp++;
        if (e1 !== 1'b1 || c1 !== 32'd1) begin
          n_bad++;
          $display("FAIL flip_err: got err=%0b cnt=%0d want err=1 cnt=1", e1, c1);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (e1 !== 1'b0) begin
          n_bad++;
          $display("FAIL err_pulse: got err=%0b want 0", e1);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (c1 !== 32'd1) begin
          n_bad++;
          $display("FAIL pre_clr_cnt: got %0d want 1", c1);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (c1 !== 32'd0 || e1 !== 1'b1) begin
          n_bad++;
          $display("FAIL clr_priority: got cnt=%0d err=%0b want cnt=0 err=1", c1, e1);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if (c1 !== 32'd1 || l1 !== 1'b1) begin
          n_bad++;
          $display("FAIL post_clr_cnt: got cnt=%0d lock=%0b want cnt=1 lock=1", c1, l1);
        end
      end
    end
    flip1 = 1'b0;
    clr1 = 1'b0;
    en1 = 1'b0;
    tick;
  endtask

  task automatic test_lock_u2;
    logic [1:0] x;
    for (int j = 1; j <= 45; j++) begin
      en2 = 1'b1;
      push2();
      tick;
      x = q2.pop_front();
      n_cmp++;
      if (v2 !== 1'b1 || d2 !== x) begin
        n_bad++;
        $display("FAIL lock_u2_sb word %0d: got valid=%0b data=%b want valid=1 data=%b", j, v2, d2, x);
      end
      if (j == 37 || j == 38) begin
        n_cmp++;
        if (l2 !== (j == 38)) begin
          n_bad++;
          $display("FAIL lock_u2 after word %0d: got lock=%0b want %0b", j - 1, l2, j == 38);
        end
      end
    end
    en2 = 1'b0;
    tick;
    n_cmp++;
    if (c2 !== 32'd0) begin
      n_bad++;
      $display("FAIL lock_u2_cnt: got %0d want 0", c2);
    end
  endtask

  task automatic test_inject;
    logic [1:0] x;
    en2 = 1'b1;
    inj2 = 1'b1;
    push2();
    tick;
    inj2 = 1'b0;
    x = q2.pop_front();
    n_cmp++;
    if (d2 !== x) begin
      n_bad++;
      $display("FAIL inject_word: got %b want %b", d2, x);
    end
    for (int i = 0; i < 12; i++) begin
      push2();
      tick;
      x = q2.pop_front();
      n_cmp++;
      if (d2 !== x) begin
        n_bad++;
        $display("FAIL inject_sb step %0d: got %b want %b", i, d2, x);
      end
    end
    en2 = 1'b0;
    tick;
    n_cmp++;
    if (c2 !== INJ_ERRS || l2 !== 1'b1) begin
      n_bad++;
      $display("FAIL inject_cnt: got cnt=%0d lock=%0b want cnt=%0d lock=1", c2, l2, INJ_ERRS);
    end
  endtask

  task automatic test_loss;
    logic [1:0] x;
    logic dropped;
    dropped = 1'b0;
    ovr2 = 1'b1;
    for (int k = 0; k < 40 && !dropped; k++) begin
      en2 = 1'b1;
      push2();
      tick;
      x = q2.pop_front();
      if (l2 === 1'b0) dropped = 1'b1;
    end
    n_cmp++;
    if (l2 !== 1'b0) begin
      n_bad++;
      $display("FAIL loss_lock: got lock=%0b want 0 within 40 words", l2);
    end
    n_cmp++;
    if (!(c2 >= 32'd8)) begin
      n_bad++;
      $display("FAIL loss_cnt: got %0d want >= 8", c2);
    end
    n_cmp++;
    if (e2 !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_err: got err=%0b want 1", e2);
    end
    ovr2 = 1'b0;
    en2 = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [1:0] x;
    logic y;
    en2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push2();
      tick;
      x = q2.pop_front();
    end
    en2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d1, v1, l1, e1, c1} !== '0) begin
      n_bad++;
      $display("FAIL rst_async_u1: got data=%0b valid=%0b lock=%0b err=%0b cnt=%0d want all 0", d1, v1, l1, e1, c1);
    end
    n_cmp++;
    if ({d2, v2, l2, e2, c2} !== '0) begin
      n_bad++;
      $display("FAIL rst_async_u2: got data=%b valid=%0b lock=%0b err=%0b cnt=%0d want all 0", d2, v2, l2, e2, c2);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({d2, v2, l2, e2, c2} !== '0) begin
      n_bad++;
      $display("FAIL rst_hold_u2: got data=%b valid=%0b lock=%0b cnt=%0d want all 0", d2, v2, l2, c2);
    end
    rst_n = 1'b1;
    p1 = 0;
    p2 = 0;
    q1.delete();
    q2.delete();
    en1 = 1'b1;
    en2 = 1'b1;
    push1();
    push2();
    tick;
    en1 = 1'b0;
    en2 = 1'b0;
    x = q2.pop_front();
    y = q1.pop_front();
    n_cmp++;
    if (v2 !== 1'b1 || d2 !== x || d2 !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_first_u2: got valid=%0b data=%b want valid=1 data=%b", v2, d2, x);
    end
    n_cmp++;
    if (v1 !== 1'b1 || d1 !== y || d1 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_first_u1: got valid=%0b data=%0b want valid=1 data=%0b", v1, d1, y);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) seq[i] = SEED_T[8-i];
    for (int i = 9; i < 1024; i++) seq[i] = seq[i-9] ^ seq[i-5];
    test_reset;
    test_gen_seq;
    test_lock_u1;
    test_clr_cnt;
    test_lock_u2;
    test_inject;
    test_loss;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
